lsu_mem_stage: RTL and testbench

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

---
 rtl/lsu_mem_stage_pkg.sv | 54 +++++
 rtl/lsu_mem_stage_load_ext.sv | 27 ++
 rtl/lsu_mem_stage.sv | 100 ++++++++++
 tb/tb_lsu_mem_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the LSU memory stage: FSM codes, RV32I width codes and lane helpers.
// Pure declarations and combinational functions; no latency or backpressure of its own.
package lsu_mem_stage_pkg;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic access_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = !we;
            F3_HU:   ok = !we && !off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Width is carried in f3[1:0]; the unsigned bit does not change the lanes touched.
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            2'b00:   lanes = {4{data[7:0]}};
            2'b01:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_load_ext.sv
// Load lane select plus sign/zero extension of the returned bus word.
// Purely combinational, zero latency; no flow control.
module load_ext
    import lsu_mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data = {24'h0, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data = {16'h0, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I load/store memory stage: issues one registered bus transaction per legal access.
// Latency: stall for the request cycle plus every WAIT cycle; bus ack or TIMEOUT ends the wait.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] dram_rd_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic          legal;
    logic [31:0]   ext_data;

    assign legal      = access_legal(we_i, funct3_i, addr_i[1:0]);
    assign misalign_o = req_i && (state == ST_IDLE) && !legal;
    assign stall_o    = rst_n_i && (((state == ST_IDLE) && req_i && legal) || (state == ST_WAIT));

    load_ext u_load_ext (
        .funct3 (f3_q),
        .offset (off_q),
        .rdata  (bus_rdata_i),
        .data   (ext_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            dram_rd_o   <= '0;
            bus_err_o   <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_i && legal) begin
                        state       <= ST_WAIT;
                        cnt         <= '0;
                        f3_q        <= funct3_i;
                        off_q       <= addr_i[1:0];
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= we_i;
                        bus_addr_o  <= {addr_i[31:2], 2'b00};
                        bus_be_o    <= byte_enables(funct3_i[1:0], addr_i[1:0]);
                        bus_wdata_o <= store_lanes(funct3_i[1:0], wdata_i);
                    end
                end
                ST_WAIT: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (bus_ack_i) begin
                        state     <= ST_DONE;
                        bus_req_o <= 1'b0;
                        if (!bus_we_o) begin
                            dram_rd_o <= ext_data;
                        end
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state     <= ST_DONE;
                        bus_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                        dram_rd_o <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed vector table, timeout and mid-wait reset sequences,
// then random accesses checked against a byte-arithmetic reference model.
module tb_lsu_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, misalign, bus_err, bus_req, bus_we, bus_ack;
    logic [31:0] dram_rd, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_i       (req),
        .we_i        (we),
        .funct3_i    (funct3),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .stall_o     (stall),
        .dram_rd_o   (dram_rd),
        .misalign_o  (misalign),
        .bus_err_o   (bus_err),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_be_o    (bus_be),
        .bus_wdata_o (bus_wdata),
        .bus_ack_i   (bus_ack),
        .bus_rdata_i (bus_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: width in bytes, lane offset, and two's-complement arithmetic on a longint.
    function automatic void ref_model(input logic m_we, input logic [2:0] m_f3,
                                      input logic [31:0] m_addr, input logic [31:0] m_wd,
                                      input logic [31:0] m_rd, output logic ok,
                                      output logic [3:0] m_be, output logic [31:0] m_wl,
                                      output logic [31:0] m_ld);
        int f, nb, off;
        longint v;
        f   = int'(m_f3);
        nb  = 1 << (f % 4);
        off = int'(m_addr % 4);
        ok  = (f == 0 || f == 1 || f == 2 || ((f == 4 || f == 5) && !m_we)) && (off % nb == 0);
        m_be = 4'(((1 << nb) - 1) << off);
        m_wl = 32'h0;
        m_ld = 32'h0;
        if (nb <= 4) begin
            for (int i = 0; i < 4; i++)
                m_wl |= ((m_wd >> (8 * (i % nb))) & 32'hFF) << (8 * i);
            v = longint'({32'h0, m_rd >> (8 * off)}) & ((longint'(1) << (8 * nb)) - 1);
            if (f < 4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                v = v - (longint'(1) << (8 * nb));
            m_ld = v[31:0];
        end
    endfunction

    // ack_at: WAIT cycle (1-based) carrying the ack; outside 1..TO means no ack at all.
    task automatic run_txn(input logic t_we, input logic [2:0] t_f3, input logic [31:0] t_addr,
                           input logic [31:0] t_wd, input logic [31:0] t_rd, input int ack_at,
                           input logic e_mis, input logic [3:0] e_be, input logic [31:0] e_wd,
                           input logic [31:0] e_rd);
        int stalls;
        int k;
        bit tmo;
        logic [31:0] fin_rd;
        stalls = 0;
        tmo    = (ack_at < 1 || ack_at > TO);
        fin_rd = tmo ? 32'h0 : e_rd;
        @(negedge clk);
        req = 1'b1; we = t_we; funct3 = t_f3; addr = t_addr; wdata = t_wd;
        bus_ack = 1'b0; bus_rdata = $urandom;
        #2;
        chk("misalign", misalign, e_mis);
        if (e_mis) begin
            chk("stall_on_illegal", stall, 0);
            @(negedge clk);
            req = 1'b0;
            #2;
            chk("bus_req_after_illegal", bus_req, 0);
            chk("dram_rd_after_illegal", dram_rd, e_rd);
            return;
        end
        if (stall) stalls++;
        k = 0;
        do begin
            k++;
            @(negedge clk);
            bus_ack   = (k == ack_at);
            bus_rdata = bus_ack ? t_rd : $urandom;
            #2;
            if (stall) stalls++;
            chk("bus_req_wait", bus_req, 1);
            chk("bus_be", bus_be, e_be);
            chk("bus_addr", bus_addr, {t_addr[31:2], 2'b00});
            chk("bus_we", bus_we, t_we);
            if (t_we) chk("bus_wdata", bus_wdata, e_wd);
        end while (!bus_ack && k < TO);
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = $urandom;
        #2;
        chk("stall_done", stall, 0);
        chk("bus_req_done", bus_req, 0);
        chk("bus_err_done", bus_err, tmo);
        chk("dram_rd_done", dram_rd, fin_rd);
        chk("stall_cycles", stalls, tmo ? TO + 1 : ack_at + 1);
        @(negedge clk);
        req = 1'b0; bus_ack = 1'b0;
        #2;
        chk("bus_err_cleared", bus_err, 0);
        chk("bus_req_idle", bus_req, 0);
        chk("dram_rd_hold", dram_rd, fin_rd);
    endtask

    initial begin
        logic        r_we, ok;
        logic [2:0]  r_f3;
        logic [31:0] r_addr, r_wd, r_rd, wl, ld, model_rd, exp_rd;
        logic [3:0]  be;
        int          r_ack;

        tbl[0]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 3, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
        tbl[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'h80FFFFFF, 2, 1'b0, 4'h8, 32'h0,        32'hFFFFFF80};
        tbl[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h80FFFFFF, 1, 1'b0, 4'h8, 32'h0,        32'h00000080};
        tbl[3]  = '{1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0,        2, 1'b0, 4'hC, 32'hABCDABCD, 32'h00000080};
        tbl[4]  = '{1'b0, 3'd2, 32'h101, 32'h0,        32'h0,        1, 1'b1, 4'h0, 32'h0,        32'h00000080};
        tbl[5]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h80011234, 1, 1'b0, 4'hC, 32'h0,        32'hFFFF8001};
        tbl[6]  = '{1'b0, 3'd5, 32'h100, 32'h0,        32'h8001F234, 4, 1'b0, 4'h3, 32'h0,        32'h0000F234};
        tbl[7]  = '{1'b1, 3'd0, 32'h301, 32'h12345678, 32'h0,        1, 1'b0, 4'h2, 32'h78787878, 32'h0000F234};
        tbl[8]  = '{1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 32'h0,        3, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0000F234};
        tbl[9]  = '{1'b1, 3'd1, 32'h201, 32'h0,        32'h0,        1, 1'b1, 4'h0, 32'h0,        32'h0000F234};
        tbl[10] = '{1'b1, 3'd4, 32'h100, 32'h0,        32'h0,        1, 1'b1, 4'h0, 32'h0,        32'h0000F234};
        tbl[11] = '{1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        1, 1'b1, 4'h0, 32'h0,        32'h0000F234};
        tbl[12] = '{1'b0, 3'd0, 32'h102, 32'h0,        32'h007F0000, 1, 1'b0, 4'h4, 32'h0,        32'h0000007F};
        tbl[13] = '{1'b0, 3'd1, 32'h100, 32'h0,        32'h12347FFF, 2, 1'b0, 4'h3, 32'h0,        32'h00007FFF};

        rst_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #2;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_dram_rd", dram_rd, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].ack_at,
                    tbl[i].mis, tbl[i].be, tbl[i].wd, tbl[i].rd);

        // No ack at all: error pulse after the TO-th WAIT cycle, load data forced to zero.
        run_txn(1'b0, 3'd2, 32'h500, 32'h0, 32'h0, 0, 1'b0, 4'hF, 32'h0, 32'h0);

        // Reset while the bus request is outstanding, then a normal load.
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h600; bus_ack = 1'b0;
        #2;
        @(negedge clk);
        #2;
        @(negedge clk);
        #2;
        chk("midwait_bus_req", bus_req, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_bus_req", bus_req, 0);
        chk("reset_stall", stall, 0);
        chk("reset_dram_rd", dram_rd, 0);
        @(negedge clk);
        rst_n = 1'b1; req = 1'b0;
        #2;
        chk("after_reset_bus_req", bus_req, 0);
        run_txn(1'b0, 3'd2, 32'h604, 32'h0, 32'h13579BDF, 2, 1'b0, 4'hF, 32'h0, 32'h13579BDF);
        model_rd = 32'h13579BDF;

        for (int n = 0; n < 40; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = $urandom;
            r_wd   = $urandom;
            r_rd   = $urandom;
            r_ack  = $urandom_range(1, 6);
            ref_model(r_we, r_f3, r_addr, r_wd, r_rd, ok, be, wl, ld);
            exp_rd = (ok && !r_we) ? ld : model_rd;
            run_txn(r_we, r_f3, r_addr, r_wd, r_rd, r_ack, !ok, be, wl, exp_rd);
            if (ok) begin
                if (r_ack > TO) model_rd = 32'h0;
                else if (!r_we) model_rd = ld;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
